// File: rtl/hankel_matrix.sv
// Fetches x[0..2N-2] from a latency-1 sample RAM and streams the N x N Hankel
// matrix H[i][j] = x[i+j] row-major, one element per cycle.
module hankel_matrix #(
    parameter int DW        = 16,
    parameter int AW        = 8,
    parameter int N         = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic [DW-1:0] h_data,
    output logic [3:0]    h_row,
    output logic [3:0]    h_col,
    output logic          h_valid,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);

    localparam int L  = 2 * N - 1;
    localparam int IW = $clog2(L);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, EMIT} state_t;

    state_t         state;
    logic [IW-1:0]  rd_cnt;
    logic [IW-1:0]  wr_idx;
    logic           rd_d;
    logic [DW-1:0]  xbuf [L];

    logic [3:0]     nrow;
    logic [3:0]     ncol;
    logic           last_elem;

    assign state_dbg = state;

    // h_valid qualifies h_data/h_row/h_col for exactly one cycle; the consumer
    // has no ready, so every valid cycle is a completed transfer.
    always_comb begin
        nrow      = h_row;
        ncol      = h_col + 4'd1;
        last_elem = (h_row == 4'(N - 1)) && (h_col == 4'(N - 1));
        if (h_col == 4'(N - 1)) begin
            nrow = h_row + 4'd1;
            ncol = 4'd0;
        end
    end

    // Sample buffer: rd_d marks the cycle in which the RAM returns read data.
    always_ff @(posedge clk) begin
        if (rd_d)
            xbuf[wr_idx] <= data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            rd      <= 1'b0;
            rd_d    <= 1'b0;
            rd_cnt  <= '0;
            wr_idx  <= '0;
            h_data  <= '0;
            h_row   <= '0;
            h_col   <= '0;
            h_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            rd_d <= rd;
            if (rd_d)
                wr_idx <= wr_idx + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= READ;
                        rd     <= 1'b1;
                        addr   <= AW'(BASE_ADDR);
                        busy   <= 1'b1;
                        rd_cnt <= '0;
                        wr_idx <= '0;
                    end
                end
                READ: begin
                    if (rd_cnt == IW'(L - 1)) begin
                        rd    <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        addr   <= addr + 1'b1;
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state   <= EMIT;
                    h_valid <= 1'b1;
                    h_row   <= '0;
                    h_col   <= '0;
                    h_data  <= xbuf[0];
                end
                EMIT: begin
                    if (last_elem) begin
                        state   <= IDLE;
                        h_valid <= 1'b0;
                        h_row   <= '0;
                        h_col   <= '0;
                        h_data  <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        h_row  <= nrow;
                        h_col  <= ncol;
                        h_data <= xbuf[IW'(nrow) + IW'(ncol)];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hankel_matrix.sv
// Scoreboard bench: two instances (BASE_ADDR 0 and 250) fed identical samples
// x[k]=k must emit the same matrix H[i][j]=i+j.
module tb_hankel_matrix;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;

    logic [15:0] data0, data1, h_data0, h_data1;
    logic [7:0]  addr0, addr1;
    logic        rd0, rd1, h_valid0, h_valid1, busy0, busy1, done0, done1;
    logic [3:0]  h_row0, h_col0, h_row1, h_col1;
    logic [1:0]  st0, st1;

    logic [23:0] exp_q[$];
    logic [7:0]  addr_q[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int t0 = 0;
    int done_cnt = 0;
    bit first_pending = 0;
    bit done_pending = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    hankel_matrix #(.DW(16), .AW(8), .N(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data0), .addr(addr0), .rd(rd0),
        .h_data(h_data0), .h_row(h_row0), .h_col(h_col0), .h_valid(h_valid0),
        .busy(busy0), .done(done0), .state_dbg(st0)
    );

    hankel_matrix #(.DW(16), .AW(8), .N(8), .BASE_ADDR(250)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data1), .addr(addr1), .rd(rd1),
        .h_data(h_data1), .h_row(h_row1), .h_col(h_col1), .h_valid(h_valid1),
        .busy(busy1), .done(done1), .state_dbg(st1)
    );

    // Latency-1 RAM models; garbage whenever no read was issued.
    always @(posedge clk) begin
        data0 <= rd0 ? {8'h00, addr0} : 16'hFFFF;
        data1 <= rd1 ? {8'h00, 8'(addr1 - 8'd250)} : 16'hFFFF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, none expected (cycle %0d)", name, act, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd0 || rd1) begin
                if (addr_q.size() == 0) fail_now("extra_read", int'(addr0));
                else begin
                    logic [7:0] k;
                    k = addr_q.pop_front();
                    chk("rd0", rd0, 1);
                    chk("rd1", rd1, 1);
                    chk("addr0", addr0, k);
                    chk("addr1_wrap", addr1, 8'(k + 8'd250));
                end
            end
            if (h_valid0 || h_valid1) begin
                if (exp_q.size() == 0) fail_now("extra_elem", int'(h_data0));
                else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    chk("h_valid0", h_valid0, 1);
                    chk("h_valid1", h_valid1, 1);
                    chk("elem0", {h_row0, h_col0, h_data0}, e);
                    chk("elem1", {h_row1, h_col1, h_data1}, e);
                    if (first_pending) begin
                        chk("first_valid_lat", cyc, t0 + 16);
                        first_pending = 0;
                    end
                end
            end else begin
                chk("idle_zero0", {h_row0, h_col0, h_data0}, 0);
                chk("idle_zero1", {h_row1, h_col1, h_data1}, 0);
            end
            if (done0 || done1) begin
                if (!done_pending) fail_now("unexpected_done", cyc);
                else begin
                    chk("done_lat", cyc, t0 + 80);
                    chk("done1", done1, 1);
                    chk("busy0_at_done", busy0, 0);
                    chk("busy1_at_done", busy1, 0);
                    done_pending = 0;
                    done_cnt++;
                end
            end
        end
    end

    // Issue one accepted start at the current negedge; optionally pulse
    // start again during READ and during EMIT, which must be ignored.
    task automatic run_matrix(input bit extra);
        int n;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                exp_q.push_back({4'(i), 4'(j), 16'(i + j)});
        for (int k = 0; k < 15; k++) addr_q.push_back(8'(k));
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        first_pending = 1;
        done_pending = 1;
        chk("busy0_start", busy0, 1);
        chk("busy1_start", busy1, 1);
        if (extra) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (30) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done0) fail_now("done_timeout", n);
        chk("elems_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rd", rd0, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_hvalid", h_valid0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of the read burst
        for (int k = 0; k < 15; k++) addr_q.push_back(8'(k));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd0", rd0, 0);
        chk("async_addr0", addr0, 0);
        chk("async_busy0", busy0, 0);
        chk("async_hvalid0", h_valid0, 0);
        chk("async_rd1", rd1, 0);
        chk("async_addr1", addr1, 0);
        addr_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_matrix(1'b0);
        repeat (3) @(negedge clk);
        run_matrix(1'b1);
        run_matrix(1'b0);   // started in the done cycle of the previous run
        repeat (20) @(negedge clk);
        chk("done_count", done_cnt, 3);
        chk("final_busy", busy0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
